double_to_sig16b_seq: RTL and testbench

- Multi-cycle converter from an IEEE-754 double to a 16-bit two's-complement sample, clocked on clk_operation.
- Returns processed doubles from the echo-cancellation datapath to the 16-bit sample domain.
- Uses the same enable/ready handshake as sig16b_to_double, so the two blocks form a round trip on the operation clock.
- Performs round-to-nearest-even and saturation, and reports overflow and NaN.

---
 rtl/double_to_sig16b_seq.sv | 149 ++++++++++++++
 tb/tb_double_to_sig16b_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/double_to_sig16b_seq.sv
// Multi-cycle IEEE-754 double to 16-bit signed sample converter with
// round-to-nearest-even (or truncation), saturation, and NaN flagging.
module double_to_sig16b_seq #(
  parameter int unsigned ROUND_MODE = 1,
  parameter logic [15:0] NAN_VALUE  = 16'h0000
) (
  input  logic        clk_operation,
  input  logic        rst,
  input  logic        enable,
  input  logic [63:0] double,
  output logic [15:0] sig16b,
  output logic        ready,
  output logic        busy,
  output logic        ovf,
  output logic        inv
);

  typedef enum logic [2:0] {IDLE, UNPACK, SHIFT, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic        enable_q;
  logic [63:0] in_q;
  logic [52:0] mant_q, mant_d;
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] sig_q, sig_d;
  logic        ovf_q, ovf_d;
  logic        inv_q, inv_d;

  logic        start;
  logic        sign;
  logic [10:0] exp_f;
  logic [51:0] frac;
  logic [15:0] sat_val;
  logic [10:0] shift_n;
  logic        round_up;
  logic [16:0] mag;
  logic [15:0] neg_mag;

  assign start    = enable & ~enable_q;
  assign sign     = in_q[63];
  assign exp_f    = in_q[62:52];
  assign frac     = in_q[51:0];
  assign sat_val  = sign ? 16'h8000 : 16'h7FFF;
  // Shift count N = 52 - (E - 1023); only evaluated for 1022 <= E <= 1037.
  assign shift_n  = 11'd1075 - exp_f;
  assign round_up = (ROUND_MODE != 0) && guard_q && (sticky_q || mant_q[0]);
  assign mag      = {1'b0, mant_q[15:0]} + {16'd0, round_up} + {mant_q[16], 16'd0};
  assign neg_mag  = ~mag[15:0] + 16'd1;

  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    sig_d    = sig_q;
    ovf_d    = ovf_q;
    inv_d    = inv_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = UNPACK;
      end
      UNPACK: begin
        state_d = DONE;
        ovf_d   = 1'b0;
        inv_d   = 1'b0;
        if (exp_f == 11'h7FF) begin
          if (frac != 52'd0) begin
            sig_d = NAN_VALUE;
            inv_d = 1'b1;
          end else begin
            sig_d = sat_val;
            ovf_d = 1'b1;
          end
        end else if (exp_f < 11'd1022) begin
          sig_d = 16'h0000;
        end else if (exp_f >= 11'd1038) begin
          // -32768.0 is the one e>=15 value that is exactly representable.
          sig_d = sat_val;
          ovf_d = !(sign && exp_f == 11'd1038 && frac == 52'd0);
        end else begin
          mant_d   = {1'b1, frac};
          cnt_d    = shift_n[5:0];
          guard_d  = 1'b0;
          sticky_d = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        mant_d   = mant_q >> 1;
        guard_d  = mant_q[0];
        sticky_d = sticky_q | guard_q;
        cnt_d    = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = ROUND;
      end
      ROUND: begin
        state_d = DONE;
        inv_d   = 1'b0;
        if (!sign && mag > 17'd32767) begin
          sig_d = 16'h7FFF;
          ovf_d = 1'b1;
        end else if (sign && mag > 17'd32768) begin
          sig_d = 16'h8000;
          ovf_d = 1'b1;
        end else begin
          sig_d = sign ? neg_mag : mag[15:0];
          ovf_d = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_operation) begin
    if (rst) begin
      state_q  <= IDLE;
      enable_q <= 1'b0;
      in_q     <= 64'd0;
      mant_q   <= 53'd0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= 6'd0;
      sig_q    <= 16'h0000;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable;
      if (state_q == IDLE && start) in_q <= double;
      mant_q   <= mant_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      sig_q    <= sig_d;
      ovf_q    <= ovf_d;
      inv_q    <= inv_d;
    end
  end

  assign sig16b = sig_q;
  assign ovf    = ovf_q;
  assign inv    = inv_q;
  assign ready  = (state_q == DONE);
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_double_to_sig16b_seq.sv
// Directed bench for double_to_sig16b_seq: one rounding instance and one
// truncating instance driven in parallel, plus an integer round-trip sweep.
module tb_double_to_sig16b_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [63:0] dbl;
  logic [15:0] sig0, sig1;
  logic        rdy0, rdy1, busy0, busy1, ovf0, ovf1, inv0, inv1;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  int          pulses, first;
  logic [15:0] r_sig0, r_sig1;
  logic        r_ovf0, r_ovf1, r_inv0, r_inv1, r_busy1, r_busy_end;

  always #5 clk = ~clk;

  double_to_sig16b_seq #(.ROUND_MODE(1), .NAN_VALUE(16'h0000)) dut_rne (
    .clk_operation(clk), .rst(rst), .enable(enable), .double(dbl),
    .sig16b(sig0), .ready(rdy0), .busy(busy0), .ovf(ovf0), .inv(inv0)
  );

  double_to_sig16b_seq #(.ROUND_MODE(0), .NAN_VALUE(16'h0000)) dut_trunc (
    .clk_operation(clk), .rst(rst), .enable(enable), .double(dbl),
    .sig16b(sig1), .ready(rdy1), .busy(busy1), .ovf(ovf1), .inv(inv1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise enable just after an edge and watch up to 70 edges; enable stays
  // high for 'hold' cycles, re-pulses at cycle 'reedge', rst pulses at 'rst_at'.
  task automatic run(input logic [63:0] d, input int hold, input int reedge,
                     input int rst_at, input bit full);
    dbl = d;
    enable = 1'b1;
    pulses = 0;
    first = 0;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk); #1;
      if (c == 1) r_busy1 = busy0;
      if (rdy0) begin
        pulses++;
        if (first == 0) begin
          first = c;
          r_sig0 = sig0; r_ovf0 = ovf0; r_inv0 = inv0;
          r_sig1 = sig1; r_ovf1 = ovf1; r_inv1 = inv1;
        end
      end
      enable = (c < hold) || (c == reedge);
      rst = (c == rst_at);
      if (rdy0 && !full) break;
    end
    rst = 1'b0;
    enable = 1'b0;
    @(posedge clk); #1;
    r_busy_end = busy0;
  endtask

  task automatic vec(input string tag, input logic [63:0] d, input logic [15:0] es,
                     input logic eo, input logic ei, input int el);
    run(d, 1, 0, 0, 1'b0);
    chk({tag, "_pulse"}, pulses, 1);
    chk({tag, "_sig"}, {16'd0, r_sig0}, {16'd0, es});
    chk({tag, "_ovf"}, {31'd0, r_ovf0}, {31'd0, eo});
    chk({tag, "_inv"}, {31'd0, r_inv0}, {31'd0, ei});
    chk({tag, "_lat"}, first, el);
    chk({tag, "_busy"}, {31'd0, r_busy1}, 32'd1);
    chk({tag, "_idle"}, {31'd0, r_busy_end}, 32'd0);
    $display("vec %s in=%h sig=%h ovf=%0d inv=%0d lat=%0d", tag, d, r_sig0, r_ovf0, r_inv0, first);
  endtask

  initial begin
    logic [15:0] v;
    rst = 1'b1;
    enable = 1'b0;
    dbl = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sig", {16'd0, sig0}, 32'd0);
    chk("rst_ready", {31'd0, rdy0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_flags", {30'd0, ovf0, inv0}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    vec("pos32768", 64'h40E0000000000000, 16'h7FFF, 1'b1, 1'b0, 2);
    vec("neg32768", 64'hC0E0000000000000, 16'h8000, 1'b0, 1'b0, 2);
    vec("tie2p5",   64'h4004000000000000, 16'h0002, 1'b0, 1'b0, 54);
    vec("tie3p5",   64'h400C000000000000, 16'h0004, 1'b0, 1'b0, 54);
    vec("tie0p5",   64'h3FE0000000000000, 16'h0000, 1'b0, 1'b0, 56);
    vec("neg1p75",  64'hBFFC000000000000, 16'hFFFE, 1'b0, 1'b0, 55);
    vec("r32767p6", 64'h40DFFFE666666666, 16'h7FFF, 1'b1, 1'b0, 41);
    chk("r32767p6_trunc_sig", {16'd0, r_sig1}, 32'h7FFF);
    chk("r32767p6_trunc_ovf", {31'd0, r_ovf1}, 32'd0);
    vec("neg3p9",   64'hC00F333333333333, 16'hFFFC, 1'b0, 1'b0, 54);
    chk("neg3p9_trunc_sig", {16'd0, r_sig1}, 32'hFFFD);
    vec("nan",      64'h7FF8000000000000, 16'h0000, 1'b0, 1'b1, 2);
    chk("nan_trunc_inv", {31'd0, r_inv1}, 32'd1);
    vec("denorm",   64'h0000000000000001, 16'h0000, 1'b0, 1'b0, 2);
    vec("negzero",  64'h8000000000000000, 16'h0000, 1'b0, 1'b0, 2);
    vec("neginf",   64'hFFF0000000000000, 16'h8000, 1'b1, 1'b0, 2);

    // Reset during SHIFT aborts the conversion and clears the held -Inf result.
    run(64'h3FF0000000000000, 1, 0, 21, 1'b1);
    chk("rstmid_pulses", pulses, 0);
    chk("rstmid_sig", {16'd0, sig0}, 32'd0);
    chk("rstmid_flags", {29'd0, ovf0, inv0, busy0}, 32'd0);
    $display("ctl rst_mid pulses=%0d sig=%h ovf=%0d", pulses, sig0, ovf0);

    run(64'h3FF0000000000000, 1, 10, 0, 1'b1);
    chk("reedge_pulses", pulses, 1);
    chk("reedge_lat", first, 55);
    chk("reedge_sig", {16'd0, r_sig0}, 32'h0001);
    $display("ctl reedge pulses=%0d lat=%0d sig=%h", pulses, first, r_sig0);

    run(64'h400C000000000000, 5, 0, 0, 1'b1);
    chk("hold5_pulses", pulses, 1);
    chk("hold5_lat", first, 54);
    chk("hold5_sig", {16'd0, r_sig0}, 32'h0004);
    $display("ctl hold5 pulses=%0d lat=%0d sig=%h", pulses, first, r_sig0);

    for (int i = 0; i < 1000; i++) begin
      v = 16'($urandom);
      run($realtobits($itor($signed(v))), 1, 0, 0, 1'b0);
      chk("rt_pulse", pulses, 1);
      chk("rt_sig", {16'd0, r_sig0}, {16'd0, v});
      chk("rt_trunc_sig", {16'd0, r_sig1}, {16'd0, v});
      chk("rt_flags", {28'd0, r_ovf0, r_inv0, r_ovf1, r_inv1}, 32'd0);
      if (i < 8) $display("rt %0d sample=%h sig=%h", i, v, r_sig0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
